cpc_exp_uart: RTL and testbench
===============================

// Module: cpc_exp_uart
// PURPOSE
// - Serial (UART) peripheral on the Amstrad CPU expansion port; responds to the Z80 I/O cycles the motherboard issues.
// - Four I/O registers at BASE_ADDR..BASE_ADDR+3.
// - Read data goes back on cpu_din; the motherboard ANDs cpu_din into the CPU data bus, so it idles at 8'hFF.
// - Raises a level irq into the motherboard INT chain.
// - 8N1 serial, 16x oversampled RX, TX and RX FIFOs.
// PARAMETERS
// - BASE_ADDR   16'hFAD0  I/O base. Select = cpu_addr[15:2]==BASE_ADDR[15:2].
// - FIFO_DEPTH  16        Entries per FIFO. Power of two, >=2.
// - DIV_RESET   8'd103    Divisor reset value; gives 9600 baud at 16 MHz ce_16.
// PORTS
// - clk       in   1  System clock.
// - reset     in   1  Synchronous, active-high.
// - ce_16     in   1  16 MHz clock enable; time base for the baud generator.
// - cpu_addr  in  16  Z80 address.
// - cpu_dout  in   8  Z80 write data.
// - cpu_din   out  8  Read data to CPU. 8'hFF unless this block is selected and io-read is active.
// - iorq      in   1  Active-high IORQ.
// - rd        in   1  Active-high RD.
// - wr        in   1  Active-high WR.
// - m1        in   1  Active-high M1. iorq&m1 (interrupt ack) is never a register access.
// - irq       out  1  Active-high level interrupt request.
// - txd       out  1  Serial out; idles 1.
// - rxd       in   1  Serial in; asynchronous.
// BEHAVIOUR
// Decode and access timing
// - sel = iorq & ~m1 & address match. acc_rd = sel&rd; acc_wr = sel&wr.
// - Each access acts exactly once, on the registered edge: write on rising acc_wr, RX pop on falling acc_rd.
// - cpu_din is combinational from registered state while acc_rd is high.
// Registers
// - off0 data. R: RX FIFO head, or 8'h00 if empty (no pop when empty). W: push TX FIFO.
// - off1 status (R). [0] rx_avail, [1] rx_full, [2] tx_idle (FIFO empty & shifter idle), [3] tx_full,
//   [4] overrun, [5] frame_err, [6] irq, [7] 0.
//   - Reading off1 clears [4] and [5] on the falling edge of acc_rd.
// - off2 control. W [0] rx_ie, [1] tx_ie, [7] flush (self-clearing; empties both FIFOs, aborts nothing in flight).
//   - R returns {7'b0... as written, bit7=0}.
// - off3 divisor (R/W). Baud tick every (div+1) ce_16 pulses = 16x oversample. New value takes effect at the next tick.
// irq
// - irq = (rx_ie & rx_avail) | (tx_ie & tx_idle), registered, one cycle of latency.
// Transmitter
// - States TX_IDLE, TX_START, TX_DATA, TX_STOP. Each state lasts 16 ticks. Data is sent LSB first.
// - IDLE -> START when the FIFO is non-empty; pops at the same time.
// - STOP -> START back-to-back if the FIFO is non-empty, with no idle gap.
// Receiver
// - rxd goes through a 2-flop synchroniser.
// - States RX_IDLE, RX_START, RX_DATA, RX_STOP.
// - A falling edge starts the tick-8 midpoint check. If the line is high at the midpoint, return to IDLE (glitch).
// - Bits are sampled at tick 8 of each bit.
// - Stop=0: discard byte, set frame_err, go to IDLE once the line is high.
// Boundaries
// - Push when TX full: byte dropped, no state change.
// - RX byte completes while RX full: byte dropped, overrun set.
// - Simultaneous push/pop on a FIFO: both happen. Count unchanged; a full FIFO accepts the push.
// - Flush coincident with a push or receive: flush wins.
// - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
// - Reset, including mid-frame: txd=1, irq=0, cpu_din=8'hFF, FIFOs empty, control=0, div=DIV_RESET, flags=0, both FSMs idle.
// STRUCTURE
// - Shared include cpc_exp_defs.vh:
//   - register offsets REG_DATA/REG_STAT/REG_CTRL/REG_DIV
//   - status/control bit indices
//   - TX/RX state encodings
// - Sub-module cpc_uart_fifo (sync FIFO: push/pop/flush, dout, full, empty), instanced once for TX and once for RX.
// - Baud generator, TX FSM, RX FSM and bus decode stay in this file.
// TESTING
// 1. Reset, then idle bus: cpu_din==8'hFF, txd==1, irq==0, read off3 -> 8'd103.
// 2. Write 8'h55 to off0, div=0: txd gives start 0, then 1,0,1,0,1,0,1,0, then stop 1. Each bit lasts 16 ce_16 pulses.
//    Status[2] is 0 during the frame and 1 one tick after stop.
// 3. Drive 8'hA3 8N1 on rxd: status[0]=1. Read off0 -> 8'hA3, then status[0]=0. With rx_ie=1, irq rises after stop and drops after the pop.
// 4. Receive FIFO_DEPTH+1 bytes without reading: status[1]=1 and status[4]=1.
//    First 16 bytes read back intact. A status read clears [4].
// 5. rxd stop bit forced 0: no FIFO entry, status[5]=1. A 4-tick low glitch: no start, no flags.
// 6. Assert reset mid-TX frame: txd==1 next cycle, status reads 8'h04, held iorq&wr with no edge produces no write.

Source files
------------

// File: rtl/cpc_exp_uart_pkg.sv
// Shared definitions for the CPC expansion-port UART: register offsets, status/control bit
// positions and the transmitter/receiver state encodings.
package cpc_exp_uart_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_DIV  = 2'd3;

    localparam int unsigned STAT_RX_AVAIL  = 0;
    localparam int unsigned STAT_RX_FULL   = 1;
    localparam int unsigned STAT_TX_IDLE   = 2;
    localparam int unsigned STAT_TX_FULL   = 3;
    localparam int unsigned STAT_OVERRUN   = 4;
    localparam int unsigned STAT_FRAME_ERR = 5;
    localparam int unsigned STAT_IRQ       = 6;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;
    localparam int unsigned CTRL_FLUSH = 7;

    typedef enum logic [1:0] {
        TxIdle  = 2'd0,
        TxStart = 2'd1,
        TxData  = 2'd2,
        TxStop  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/cpc_uart_fifo.sv
// Synchronous FIFO with flush. A full FIFO still accepts a push when a pop happens in the
// same cycle; flush overrides any coincident push or pop.
module cpc_uart_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCnt);
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpc_exp_uart.sv
// 8N1 UART on the Amstrad CPU expansion port: four I/O registers, TX/RX FIFOs, 16x
// oversampled receiver and a level interrupt into the motherboard INT chain.
module cpc_exp_uart
    import cpc_exp_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFAD0,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  DIV_RESET  = 8'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_16,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        m1,
    output logic        irq,
    output logic        txd,
    input  logic        rxd
);

    logic       sel, acc_rd, acc_wr, acc_rd_q, acc_wr_q, wr_stb, rd_done;
    logic [1:0] rd_off_q;
    logic       rx_ie_q, tx_ie_q, overrun_q, frame_q, irq_q;
    logic [7:0] div_q, div_act_q, baud_cnt_q;
    logic       tick, flush, tx_push, tx_pop, rx_push, rx_pop, tx_idle;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_dout, rx_dout, status;

    assign sel     = iorq & ~m1 & (cpu_addr[15:2] == BASE_ADDR[15:2]);
    assign acc_rd  = sel & rd;
    assign acc_wr  = sel & wr;
    assign wr_stb  = acc_wr & ~acc_wr_q;
    assign rd_done = ~acc_rd & acc_rd_q;

    assign flush   = wr_stb & (cpu_addr[1:0] == REG_CTRL) & cpu_dout[CTRL_FLUSH];
    assign tx_push = wr_stb & (cpu_addr[1:0] == REG_DATA);
    assign rx_pop  = rd_done & (rd_off_q == REG_DATA) & ~rx_empty;

    // Edge history keeps sampling through reset so an access held across reset is not replayed.
    always_ff @(posedge clk) begin
        acc_rd_q <= acc_rd;
        acc_wr_q <= acc_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_off_q <= REG_DATA;
            rx_ie_q  <= 1'b0;
            tx_ie_q  <= 1'b0;
            div_q    <= DIV_RESET;
        end else begin
            if (acc_rd) begin
                rd_off_q <= cpu_addr[1:0];
            end
            if (wr_stb && cpu_addr[1:0] == REG_CTRL) begin
                rx_ie_q <= cpu_dout[CTRL_RX_IE];
                tx_ie_q <= cpu_dout[CTRL_TX_IE];
            end
            if (wr_stb && cpu_addr[1:0] == REG_DIV) begin
                div_q <= cpu_dout;
            end
        end
    end

    // The active divisor is only reloaded on a tick, so a rewrite never truncates a period.
    assign tick = ce_16 & (baud_cnt_q == div_act_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_q <= '0;
            div_act_q  <= DIV_RESET;
        end else if (ce_16) begin
            if (tick) begin
                baud_cnt_q <= '0;
                div_act_q  <= div_q;
            end else begin
                baud_cnt_q <= baud_cnt_q + 8'd1;
            end
        end
    end

    cpc_uart_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_tx_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .flush_i (flush),
        .din_i   (cpu_dout),
        .dout_o  (tx_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    // Transmitter
    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            case (tx_state_q)
                TxIdle: begin
                    tx_cnt_d = '0;
                    if (!tx_empty && !flush) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_state_d = TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_bit_d   = '0;
                        tx_state_d = TxData;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TxStop;
                        end
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == 4'd15) begin
                        if (!tx_empty && !flush) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_dout;
                            tx_state_d = TxStart;
                        end else begin
                            tx_state_d = TxIdle;
                        end
                    end
                end
                default: tx_state_d = TxIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        txd = 1'b1;
        if (tx_state_q == TxStart) begin
            txd = 1'b0;
        end else if (tx_state_q == TxData) begin
            txd = tx_shift_q[0];
        end
    end

    assign tx_idle = tx_empty & (tx_state_q == TxIdle);

    // Receiver
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_s1_q, rx_s2_q, rx_prev_q;
    logic       overrun_set, frame_set;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        overrun_set = 1'b0;
        frame_set   = 1'b0;
        if (tick) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
            case (rx_state_q)
                RxIdle: begin
                    rx_cnt_d = '0;
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_d = RxStart;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s2_q ? RxIdle : RxData;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RxStop;
                        end
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_state_d = RxIdle;
                        if (!rx_s2_q) begin
                            frame_set = 1'b1;
                        end else if (rx_full && !rx_pop) begin
                            overrun_set = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            if (tick) begin
                rx_prev_q <= rx_s2_q;
            end
        end
    end

    cpc_uart_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_rx_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .flush_i (flush),
        .din_i   (rx_shift_q),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Sticky error flags: a new error in the same cycle as the clearing read wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (rd_done && rd_off_q == REG_STAT) begin
                overrun_q <= 1'b0;
            end
            if (frame_set) begin
                frame_q <= 1'b1;
            end else if (rd_done && rd_off_q == REG_STAT) begin
                frame_q <= 1'b0;
            end
            irq_q <= (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_idle);
        end
    end

    assign irq = irq_q;

    always_comb begin
        status                 = '0;
        status[STAT_RX_AVAIL]  = ~rx_empty;
        status[STAT_RX_FULL]   = rx_full;
        status[STAT_TX_IDLE]   = tx_idle;
        status[STAT_TX_FULL]   = tx_full;
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_FRAME_ERR] = frame_q;
        status[STAT_IRQ]       = irq_q;
    end

    always_comb begin
        cpu_din = 8'hFF;
        if (acc_rd) begin
            case (cpu_addr[1:0])
                REG_DATA: cpu_din = rx_empty ? 8'h00 : rx_dout;
                REG_STAT: cpu_din = status;
                REG_CTRL: cpu_din = {6'b0, tx_ie_q, rx_ie_q};
                default:  cpu_din = div_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cpc_exp_uart.sv
// Directed bench for cpc_exp_uart: a register-access vector table followed by serial
// TX/RX, overrun, framing, glitch and reset sequences. Divisor 1 with ce_16 held high.
module tb_cpc_exp_uart;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_16 = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  cpu_din;
    logic        iorq = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        m1 = 1'b0;
    logic        irq;
    logic        txd;
    logic        rxd = 1'b1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cpc_exp_uart #(
        .BASE_ADDR  (16'hFAD0),
        .FIFO_DEPTH (16),
        .DIV_RESET  (8'd103)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce_16    (ce_16),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .iorq     (iorq),
        .rd       (rd),
        .wr       (wr),
        .m1       (m1),
        .irq      (irq),
        .txd      (txd),
        .rxd      (rxd)
    );

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        bit          m1v;
        logic [7:0]  data;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_read(input logic [15:0] a, input bit m1v, output logic [7:0] d);
        cpu_addr = a;
        m1 = m1v;
        iorq = 1'b1;
        rd = 1'b1;
        @(negedge clk);
        d = cpu_din;
        iorq = 1'b0;
        rd = 1'b0;
        m1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic io_write(input logic [15:0] a, input bit m1v, input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        m1 = m1v;
        iorq = 1'b1;
        wr = 1'b1;
        @(negedge clk);
        iorq = 1'b0;
        wr = 1'b0;
        m1 = 1'b0;
        @(negedge clk);
    endtask

    // One bit lasts 16 ticks of 2 clocks each at divisor 1.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        wait_clks(32);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(32);
        end
        rxd = stop;
        wait_clks(32);
        rxd = 1'b1;
        wait_clks(32);
    endtask

    task automatic wait_txd_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] tx_byte;
        bit         ok;

        vecs[0]  = '{0, 16'hFAD3, 0, 8'h00, 8'h67, "div_reset"};
        vecs[1]  = '{0, 16'hFAD1, 0, 8'h00, 8'h04, "stat_reset"};
        vecs[2]  = '{0, 16'hFAD2, 0, 8'h00, 8'h00, "ctrl_reset"};
        vecs[3]  = '{0, 16'hFAD0, 0, 8'h00, 8'h00, "data_empty"};
        vecs[4]  = '{1, 16'hFAD2, 0, 8'h02, 8'h00, "wr_ctrl_txie"};
        vecs[5]  = '{0, 16'hFAD2, 0, 8'h00, 8'h02, "ctrl_readback"};
        vecs[6]  = '{0, 16'hFAD1, 0, 8'h00, 8'h44, "stat_tx_irq"};
        vecs[7]  = '{1, 16'hFAD2, 0, 8'h80, 8'h00, "wr_ctrl_flush"};
        vecs[8]  = '{0, 16'hFAD2, 0, 8'h00, 8'h00, "ctrl_flush_clr"};
        vecs[9]  = '{0, 16'hFAD1, 0, 8'h00, 8'h04, "stat_irq_off"};
        vecs[10] = '{0, 16'hFAD4, 0, 8'h00, 8'hFF, "unsel_above"};
        vecs[11] = '{0, 16'hFACF, 0, 8'h00, 8'hFF, "unsel_below"};
        vecs[12] = '{0, 16'hFAD3, 1, 8'h00, 8'hFF, "m1_int_ack"};
        vecs[13] = '{1, 16'hFAD3, 1, 8'h22, 8'h00, "wr_m1_ignored"};
        vecs[14] = '{1, 16'hFAD7, 0, 8'h22, 8'h00, "wr_unsel"};
        vecs[15] = '{0, 16'hFAD3, 0, 8'h00, 8'h67, "div_untouched"};
        vecs[16] = '{1, 16'hFAD3, 0, 8'h01, 8'h00, "wr_div"};
        vecs[17] = '{0, 16'hFAD3, 0, 8'h00, 8'h01, "div_readback"};

        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        check("idle_din", cpu_din, 8'hFF);
        check("idle_txd", {7'b0, txd}, 8'h01);
        check("idle_irq", {7'b0, irq}, 8'h00);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                io_write(vecs[i].addr, vecs[i].m1v, vecs[i].data);
            end else begin
                io_read(vecs[i].addr, vecs[i].m1v, d);
                check(vecs[i].name, d, vecs[i].exp);
            end
        end
        wait_clks(250);

        // Transmit 8'h55, sampling mid-bit.
        tx_byte = 8'h55;
        io_write(16'hFAD0, 0, tx_byte);
        io_read(16'hFAD1, 0, d);
        check("tx_busy_stat", d, 8'h00);
        wait_txd_low(ok);
        check("tx_start_seen", {7'b0, ok}, 8'h01);
        wait_clks(16);
        check("tx_start_bit", {7'b0, txd}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            wait_clks(32);
            check($sformatf("tx_bit%0d", i), {7'b0, txd}, {7'b0, tx_byte[i]});
        end
        wait_clks(32);
        check("tx_stop_bit", {7'b0, txd}, 8'h01);
        wait_clks(32);
        io_read(16'hFAD1, 0, d);
        check("tx_idle_stat", d, 8'h04);

        // Receive 8'hA3 with rx_ie set.
        io_write(16'hFAD2, 0, 8'h01);
        wait_clks(2);
        check("rx_irq_before", {7'b0, irq}, 8'h00);
        send_byte(8'hA3, 1'b1);
        check("rx_irq_after", {7'b0, irq}, 8'h01);
        io_read(16'hFAD1, 0, d);
        check("rx_stat_avail", d, 8'h45);
        io_read(16'hFAD0, 0, d);
        check("rx_data", d, 8'hA3);
        wait_clks(2);
        check("rx_irq_popped", {7'b0, irq}, 8'h00);
        io_read(16'hFAD1, 0, d);
        check("rx_stat_empty", d, 8'h04);

        // Overrun: 17 bytes into a 16-entry FIFO.
        io_write(16'hFAD2, 0, 8'h00);
        for (int k = 0; k < 17; k++) begin
            send_byte(8'(k * 13 + 5), 1'b1);
        end
        io_read(16'hFAD1, 0, d);
        check("ovr_stat", d, 8'h17);
        io_read(16'hFAD1, 0, d);
        check("ovr_cleared", d, 8'h07);
        for (int k = 0; k < 16; k++) begin
            io_read(16'hFAD0, 0, d);
            check($sformatf("ovr_data%0d", k), d, 8'(k * 13 + 5));
        end
        io_read(16'hFAD1, 0, d);
        check("ovr_drained", d, 8'h04);

        // Framing error, then a short low glitch.
        send_byte(8'hF0, 1'b0);
        io_read(16'hFAD1, 0, d);
        check("frame_stat", d, 8'h24);
        io_read(16'hFAD0, 0, d);
        check("frame_no_data", d, 8'h00);
        io_read(16'hFAD1, 0, d);
        check("frame_cleared", d, 8'h04);
        rxd = 1'b0;
        wait_clks(8);
        rxd = 1'b1;
        wait_clks(400);
        io_read(16'hFAD1, 0, d);
        check("glitch_stat", d, 8'h04);
        io_read(16'hFAD0, 0, d);
        check("glitch_no_data", d, 8'h00);

        // Reset mid-frame with a write held across it.
        io_write(16'hFAD2, 0, 8'h02);
        io_write(16'hFAD0, 0, 8'h00);
        wait_txd_low(ok);
        check("rst_tx_started", {7'b0, ok}, 8'h01);
        wait_clks(20);
        reset = 1'b1;
        cpu_addr = 16'hFAD3;
        cpu_dout = 8'h22;
        iorq = 1'b1;
        wr = 1'b1;
        @(negedge clk);
        check("rst_txd", {7'b0, txd}, 8'h01);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_din", cpu_din, 8'hFF);
        wait_clks(1);
        reset = 1'b0;
        wait_clks(3);
        iorq = 1'b0;
        wr = 1'b0;
        wait_clks(1);
        io_read(16'hFAD3, 0, d);
        check("rst_div_nowrite", d, 8'h67);
        io_read(16'hFAD1, 0, d);
        check("rst_stat", d, 8'h04);
        io_read(16'hFAD2, 0, d);
        check("rst_ctrl", d, 8'h00);
        wait_clks(50);
        check("rst_txd_held", {7'b0, txd}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
